// File: rtl/hall_pkg.sv
// Shared types and default constants for the hall-sensor speed meter.
package hall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } hall_state_e;

    localparam int DEF_GATE_CYCLES   = 25_000_000;
    localparam int DEF_FILTER_CYCLES = 16;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_PER_W         = 32;

endpackage

// File: rtl/hall_input_filter.sv
// Synchronizes the raw hall line, rejects short glitches and flags rising edges.
module hall_input_filter #(
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic sa_in,
    output logic filtered,
    output logic rise
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    sync_ff;
    logic [FW-1:0] stab_cnt;
    logic          filtered_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_ff    <= '0;
            stab_cnt   <= '0;
            filtered   <= 1'b0;
            filtered_d <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[0], sa_in};
            filtered_d <= filtered;
            // Any return to agreement restarts the stability count.
            if (sync_ff[1] == filtered) begin
                stab_cnt <= '0;
            end else if (stab_cnt == FW'(FILTER_CYCLES - 1)) begin
                filtered <= sync_ff[1];
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + FW'(1);
            end
        end
    end

    assign rise = filtered & ~filtered_d;

endmodule

// File: rtl/hall_speed_meter.sv
// Gate-window edge counter and edge-to-edge period timer for the hall sensor.
module hall_speed_meter
    import hall_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int PER_W         = DEF_PER_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sa_in,
    input  logic             enable,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [PER_W-1:0] TMAX = '1;
    localparam logic [PER_W-1:0] TPRE = TMAX - PER_W'(1);
    localparam logic [CNT_W-1:0] AMAX = '1;

    hall_state_e      state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_next;
    logic [PER_W-1:0] timer;
    logic             rise;
    logic             filtered_unused;
    logic             gate_close;

    hall_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
        .clk     (clk),
        .resetn  (resetn),
        .sa_in   (sa_in),
        .filtered(filtered_unused),
        .rise    (rise)
    );

    assign gate_close = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign acc_next   = (rise && acc != AMAX) ? acc + CNT_W'(1) : acc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            gate_cnt     <= '0;
            acc          <= '0;
            timer        <= '0;
            edge_count   <= '0;
            count_valid  <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            count_valid  <= 1'b0;
            period_valid <= 1'b0;
            if (!enable) begin
                // A rise coinciding with the enable drop is dropped here.
                state    <= ST_IDLE;
                gate_cnt <= '0;
                acc      <= '0;
                timer    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ARMED;
                        gate_cnt <= '0;
                        acc      <= '0;
                        timer    <= '0;
                    end
                    default: begin
                        // The closing window absorbs a rise that lands on its last cycle.
                        if (gate_close) begin
                            gate_cnt    <= '0;
                            edge_count  <= acc_next;
                            count_valid <= 1'b1;
                            acc         <= '0;
                        end else begin
                            gate_cnt <= gate_cnt + GW'(1);
                            acc      <= acc_next;
                        end

                        if (rise) begin
                            timer <= PER_W'(1);
                            if (state == ST_ARMED) begin
                                state   <= ST_RUN;
                                stalled <= 1'b0;
                            end else if (stalled) begin
                                stalled <= 1'b0;
                            end else begin
                                period       <= timer;
                                period_valid <= 1'b1;
                            end
                        end else if (timer != TMAX) begin
                            timer <= timer + PER_W'(1);
                            if (timer == TPRE) begin
                                stalled <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_speed_meter.sv
// Directed bench for hall_speed_meter with small gate/filter/period parameters.
module tb_hall_speed_meter;

    localparam int CNT_W = 16;
    localparam int PER_W = 12;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             sa_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] edge_count;
    logic             count_valid;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;

    hall_speed_meter #(
        .GATE_CYCLES  (1000),
        .FILTER_CYCLES(4),
        .CNT_W        (CNT_W),
        .PER_W        (PER_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sa_in       (sa_in),
        .enable      (enable),
        .edge_count  (edge_count),
        .count_valid (count_valid),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int width;
        int gap;
        int exp_pv;
        int exp_period;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pv_cnt = 0;
    int pv_last = 0;
    int pv_non100 = 0;
    int cv_cnt = 0;
    int cv_last = 0;
    int cv_time[$];
    int cv_val[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            pv_cnt++;
            pv_last = int'(period);
            if (period !== 12'd100) pv_non100++;
        end
        if (count_valid === 1'b1) begin
            cv_cnt++;
            cv_last = int'(edge_count);
            cv_time.push_back(cyc);
            cv_val.push_back(int'(edge_count));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_wave(input int n, input int hi, input int lo);
        repeat (n) begin
            sa_in = 1'b1;
            tick(hi);
            sa_in = 1'b0;
            tick(lo);
        end
    endtask

    // Asserts reset between clock edges and expects outputs to clear at once.
    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("rst_edge_count", 32'(edge_count), 0);
        check("rst_period", 32'(period), 0);
        check("rst_count_valid", 32'(count_valid), 0);
        check("rst_period_valid", 32'(period_valid), 0);
        check("rst_stalled", 32'(stalled), 0);
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        int bad;
        int c0;
        int snap_pv;
        int snap_cv;
        int n;
        bit got;

        vecs[0] = '{width: 3,  gap: 100, exp_pv: 0, exp_period: 0};
        vecs[1] = '{width: 4,  gap: 100, exp_pv: 1, exp_period: 100};
        vecs[2] = '{width: 1,  gap: 60,  exp_pv: 0, exp_period: 0};
        vecs[3] = '{width: 2,  gap: 80,  exp_pv: 0, exp_period: 0};
        vecs[4] = '{width: 5,  gap: 150, exp_pv: 1, exp_period: 150};
        vecs[5] = '{width: 8,  gap: 77,  exp_pv: 1, exp_period: 77};
        vecs[6] = '{width: 4,  gap: 40,  exp_pv: 1, exp_period: 40};

        // Reset and idle hold
        do_reset();
        bad = 0;
        repeat (20) begin
            tick(1);
            if (edge_count !== '0 || period !== '0 || count_valid !== 1'b0 ||
                period_valid !== 1'b0 || stalled !== 1'b0) bad++;
        end
        check("idle_hold_zero", 32'(bad), 0);

        // Steady square wave; rises land on cycles 101+100j, so every tenth is on gate close
        pv_cnt = 0; pv_non100 = 0; cv_cnt = 0;
        cv_time.delete(); cv_val.delete();
        c0 = cyc;
        enable = 1'b1;
        tick(94);
        pulse_wave(30, 50, 50);
        tick(910);
        check("steady_cv_count", 32'(cv_cnt), 4);
        check("steady_pv_count", 32'(pv_cnt), 29);
        check("steady_pv_non100", 32'(pv_non100), 0);
        check("steady_period", 32'(period), 100);
        if (cv_val.size() == 4) begin
            check("gate_boundary_win1", 32'(cv_val[0]), 10);
            check("steady_win2", 32'(cv_val[1]), 10);
            check("gate_boundary_win3", 32'(cv_val[2]), 10);
            check("gate_acc_restart_win4", 32'(cv_val[3]), 0);
            check("first_cv_latency", 32'(cv_time[0] - c0), 1001);
            check("cv_interval", 32'(cv_time[3] - cv_time[2]), 1000);
        end

        // Mid-operation asynchronous reset, then glitch table
        do_reset();
        enable = 1'b1;
        tick(5);
        for (int i = 0; i < 7; i++) begin
            sa_in = 1'b1;
            tick(10);
            snap_pv = pv_cnt;
            tick(10);
            sa_in = 1'b0;
            tick(vecs[i].gap - 20);
            sa_in = 1'b1;
            tick(vecs[i].width);
            sa_in = 1'b0;
            tick(30);
            check($sformatf("glitch_w%0d_pv", vecs[i].width), 32'(pv_cnt - snap_pv),
                  32'(vecs[i].exp_pv));
            if (vecs[i].exp_pv != 0)
                check($sformatf("glitch_w%0d_period", vecs[i].width), 32'(pv_last),
                      32'(vecs[i].exp_period));
        end

        // Stall: timer saturates 4094 cycles after the reference rise
        sa_in = 1'b1;
        tick(20);
        sa_in = 1'b0;
        tick(4080);
        check("stall_before_sat", 32'(stalled), 0);
        tick(1);
        check("stall_at_sat", 32'(stalled), 1);
        tick(900);
        sa_in = 1'b1;
        snap_pv = pv_cnt;
        tick(10);
        check("stall_cleared", 32'(stalled), 0);
        check("stall_rise_no_pv", 32'(pv_cnt), 32'(snap_pv));
        tick(10);
        sa_in = 1'b0;
        tick(180);
        sa_in = 1'b1;
        tick(10);
        check("post_stall_pv", 32'(pv_cnt - snap_pv), 1);
        check("post_stall_period", 32'(pv_last), 200);
        tick(10);
        sa_in = 1'b0;
        tick(20);

        // Enable drop mid-window, then re-enable
        enable = 1'b0;
        tick(5);
        do_reset();
        pv_cnt = 0; cv_cnt = 0;
        enable = 1'b1;
        tick(94);
        pulse_wave(12, 50, 50);
        tick(6);
        check("pre_drop_cv_count", 32'(cv_cnt), 1);
        check("pre_drop_count", 32'(cv_last), 10);
        enable = 1'b0;
        tick(2);
        snap_cv = cv_cnt;
        snap_pv = pv_cnt;
        pulse_wave(5, 50, 50);
        tick(10);
        check("drop_hold_count", 32'(edge_count), 10);
        check("drop_hold_period", 32'(period), 100);
        check("drop_no_cv", 32'(cv_cnt), 32'(snap_cv));
        check("drop_no_pv", 32'(pv_cnt), 32'(snap_pv));

        snap_pv = pv_cnt;
        enable = 1'b1;
        n = 0;
        got = 1'b0;
        fork
            begin
                while (n < 1100 && !got) begin
                    tick(1);
                    n++;
                    if (count_valid === 1'b1) got = 1'b1;
                end
            end
            begin
                tick(3);
                sa_in = 1'b1;
                tick(10);
                check("reen_first_rise_no_pv", 32'(pv_cnt), 32'(snap_pv));
                tick(40);
                sa_in = 1'b0;
                tick(50);
                pulse_wave(8, 50, 50);
            end
        join
        check("reen_cv_latency", 32'(n), 1001);
        check("reen_count", 32'(edge_count), 9);
        tick(5);
        check("reen_pv_count", 32'(pv_cnt - snap_pv), 8);
        check("reen_period", 32'(pv_last), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hall_speed_meter.md
# hall_speed_meter

Measures motor shaft speed from the hall-effect sensor output SA on debug header pin JA[2]. It sits directly upstream of the embedded system's SA input: it conditions the raw sensor line, then counts rising edges per fixed gate window and measures the clock-cycle period between consecutive edges. The PID software reads both results as its feedback for the EN/DIR motor drive.

## Interface
- GATE_CYCLES, 25_000_000: gate window length in clk cycles (0.25 s at 100 MHz).
- FILTER_CYCLES, 16: cycles the synchronized input must be stable before the filtered level changes; ≥2.
- CNT_W, 16: width of edge_count.
- PER_W, 32: width of period and the internal period timer.
- clk  in  1  system clock, 100 MHz.
- resetn  in  1  reset, asynchronous and active-low.
- sa_in  in  1  raw hall sensor level (asynchronous to clk).
- enable  in  1  measurement enable; low forces IDLE.
- edge_count  out  CNT_W  rising edges counted in the last completed gate window.
- count_valid  out  1  one-cycle pulse when edge_count updates.
- period  out  PER_W  clk cycles between the last two accepted rising edges.
- period_valid  out  1  one-cycle pulse when period updates.
- stalled  out  1  high while no edge has been seen for 2^PER_W−1 cycles.

## Operation
- Input path: 2-flop synchronizer, then filter. A counter increments each cycle that sync_out ≠ filtered and clears whenever they are equal. When the counter would reach FILTER_CYCLES, filtered takes sync_out and the counter clears. rise = filtered & ~filtered_d.
- FSM states:
  - IDLE: enable=0. All counters clear. Outputs hold their last values. Valids low.
  - ARMED: waiting for the first rise.
  - RUN: normal measurement.
- Transitions:
  - IDLE→ARMED when enable=1.
  - ARMED→RUN on rise.
  - any state→IDLE when enable=0.
- Gate counter: runs in ARMED and RUN, 0..GATE_CYCLES−1. It is cleared on IDLE→ARMED.
- Gate close (gate_cnt==GATE_CYCLES−1):
  - edge_count ← acc + rise, saturating at 2^CNT_W−1.
  - acc ← 0.
  - count_valid pulses.
- Other cycles: acc ← acc + rise, saturating.
- Period timer:
  - On a rise in ARMED, timer ← 1 and no period is produced.
  - On a rise in RUN with stalled=0: period ← timer, period_valid pulses, timer ← 1.
  - On a rise in RUN with stalled=1: stalled ← 0, timer ← 1, no period update.
  - Other cycles: timer increments, saturating at 2^PER_W−1. Reaching saturation sets stalled.
- Simultaneous rise and gate close: the rise counts in the closing window.

## Timing
- Reset values: edge_count=0, period=0, count_valid=0, period_valid=0, stalled=0. Internally: FSM=IDLE, filtered=0, all counters 0.
- Latency from a sa_in change to the filtered change is 2 (synchronizer) + FILTER_CYCLES cycles. A pulse of fewer than FILTER_CYCLES stable synchronized cycles is rejected.
- Outputs are registered. period_valid rises 1 cycle after the cycle with rise=1; count_valid rises 1 cycle after gate close.
- Reset mid-operation: all state returns immediately to reset values, asynchronously. The first window and first period after release follow the ARMED rules.
- The enable drop takes effect the next clock edge; a rise in that same cycle is discarded.

## Structure
- Shared package hall_pkg: the FSM state enum (IDLE/ARMED/RUN) and the default constants for GATE_CYCLES, FILTER_CYCLES, CNT_W and PER_W.
- Sub-module hall_input_filter: synchronizer, stability filter and rise detector. It outputs filtered and rise.
- The top level holds the FSM, the gate counter, acc, the period timer and the output registers.

## Test plan
Bench parameters: FILTER_CYCLES=4, GATE_CYCLES=1000, PER_W=12.
1. Reset: assert resetn=0 mid-clock. All outputs are 0 immediately and stay 0 for 20 cycles after release with enable=0.
2. Steady input: enable=1 with a sa_in square wave of period 100 cycles (50 high / 50 low).
   - period=100 with period_valid on every rise after the first.
   - edge_count=10 with count_valid every 1000 cycles.
3. Glitch rejection:
   - A 3-cycle high pulse on a low line produces no rise and no count change.
   - A 4-cycle pulse is accepted, with rise 6 cycles after the sa_in edge.
4. Gate boundary: place a rise exactly on the gate-close cycle. It is included in the closing edge_count (e.g. 10→11), and the next window starts at acc=0.
5. Stall:
   - Hold sa_in low for 5000 cycles after a rise; stalled=1 at timer 4095.
   - The next rise clears stalled without period_valid.
   - The following rise 200 cycles later gives period=200.
6. Enable drop: drop enable mid-window and re-enable.
   - Valids stay low and outputs hold while enable is low.
   - After re-enable, the first rise gives no period_valid and the first count_valid arrives exactly 1001 cycles after enable returns high.
